fu_issue_controller: RTL and testbench
======================================

Name: fu_issue_controller

Overview:
Initiator side of the two-stage combined functional unit. It accepts decoded instructions (op, three operands, destination index) over a valid/ready handshake and drives the FU's op, operands and enable. It tracks the single in-flight FU stage and presents the registered FU result with its destination over a valid/ready writeback handshake. It also handles HALT draining and keeps issue/retire counters for the PE.

Parameters:
DST_WIDTH, 3, width of destination register index.
COUNTER_WIDTH, 32, width of the issued/retired counters (wrap modulo 2^COUNTER_WIDTH).

Ports:
clock  input  1  clock, positive-edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  instruction offered.
in_ready  output  1  controller accepts instruction this cycle.
in_op  input  TIA_OP_WIDTH  opcode.
in_operand_0/1/2  input  TIA_WORD_WIDTH each  operands.
in_dst  input  DST_WIDTH  destination index.
fu_enable  output  1  FU capture enable.
fu_op  output  TIA_OP_WIDTH  to FU op.
fu_operand_0/1/2  output  TIA_WORD_WIDTH each  to FU operands.
fu_result  input  TIA_WORD_WIDTH  registered FU result.
wb_valid  output  1  writeback offered.
wb_ready  input  1  writeback consumer accepts.
wb_result  output  TIA_WORD_WIDTH  result to write.
wb_dst  output  DST_WIDTH  destination of wb_result.
halted  output  1  HALT retired; controller idle until reset.
issued_count  output  COUNTER_WIDTH  instructions accepted.
retired_count  output  COUNTER_WIDTH  stage entries retired, including the silent HALT.

Behaviour:
- Reset (reset low, async): state RUN, stage_valid=0, stage_dst=0, stage_halt=0, halted=0, counters=0. All outputs are 0 during reset except the fu_op/fu_operand pass-through.
- fu_op and fu_operand_* are combinational pass-through of in_op and in_operand_*. fu_enable = issue_fire = in_valid & in_ready. The FU therefore only captures on accepted issues and holds otherwise.
- Stage register (valid, dst, halt flag) updates on issue_fire with in_dst and (in_op==TIA_OP_HALT). Latency is 1 cycle: an instruction accepted in cycle N is offered on wb in cycle N+1.
- Retire condition: stage_valid & (stage_halt | wb_ready).
- wb_valid = stage_valid & ~stage_halt. wb_result = fu_result. wb_dst = stage_dst.
- in_ready (RUN only) = ~stage_valid | retire. A new issue and a retire in the same cycle replace the stage entry, giving back-to-back throughput of 1/cycle.
- stage_valid next = issue_fire ? 1 : (retire ? 0 : stage_valid).
- wb_valid, once asserted, holds and wb_result/wb_dst are stable until wb_ready.
- FSM:
  - RUN: on accepting HALT, go to DRAIN.
  - DRAIN: in_ready=0. The HALT entry retires silently next cycle (no wb_valid). Go to HALTED.
  - HALTED: in_ready=0, halted=1, stays until reset.
- Counters: issued_count increments on issue_fire; retired_count increments on retire. Both wrap.
- in_valid while HALTED: ignored, no FU enable.
- Reset asserted mid-operation drops the in-flight entry with no writeback.

Optional Feature:
FU_ISSUE_OUTPUT_SKID_EN.
- Defined: a 2-entry skid FIFO sits between the stage and wb. Retire becomes "skid not full". in_ready = (~stage_valid | skid has space) and no longer depends combinationally on wb_ready. Latency to wb_valid becomes 2 cycles. HALT reaches HALTED only after the skid empties.
- Undefined: behaviour as above, with a combinational wb_ready→in_ready path.

Decomposition:
- Shared datapath package holds:
  - TIA_OP_* encodings and TIA_OP_WIDTH/TIA_WORD_WIDTH.
  - A new enum issue_state_t {RUN, DRAIN, HALTED}.
  - A packed struct stage_entry_t {valid, dst, halt}.
- Sub-module fu_issue_skid_buffer (2-entry FIFO of {result, dst}), instantiated only under the macro.

Test Plan:
- Single ADD 3+4, dst=5, wb_ready=1 → wb_valid one cycle later, wb_result=7, wb_dst=5, issued=retired=1.
- Back-to-back SUB 10-3 then LMUL 6*7 with wb_ready=1 → wb results 7 then 42 on consecutive cycles, in_ready held 1.
- ADD 1+1 with wb_ready=0 for 3 cycles → wb_valid=1, wb_result=2 stable, in_ready=0, fu_enable=0 while in_valid=1. On wb_ready=1, the next instruction is accepted the same cycle.
- MOV 9, dst=2, then HALT → wb 9/dst 2, HALT never raises wb_valid, halted=1 two cycles after HALT issue, in_ready stays 0 with in_valid=1, issued=retired=2.
- Assert reset low mid-stall (stage_valid=1, wb_ready=0) → wb_valid, counters and halted go 0 immediately (async), not waiting for a clock edge.
- With FU_ISSUE_OUTPUT_SKID_EN, wb_ready=0 → exactly 3 instructions accepted (stage + 2 skid) before in_ready=0. Releasing wb_ready drains them in order.

Source files
------------

// File: rtl/fu_issue_controller_pkg.sv
// Shared datapath definitions for the FU issue controller: opcode encodings,
// datapath widths, issue FSM states and the single-stage tracking entry.
package fu_issue_controller_pkg;

    localparam int TIA_OP_WIDTH    = 5;
    localparam int TIA_WORD_WIDTH  = 32;
    localparam int STAGE_DST_WIDTH = 3;

    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_NOP  = 5'd0;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_MOV  = 5'd1;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_ADD  = 5'd2;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_SUB  = 5'd3;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_LMUL = 5'd4;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_LMAC = 5'd5;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_AND  = 5'd6;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_OR   = 5'd7;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_XOR  = 5'd8;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_HALT = 5'd31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic                       valid;
        logic [STAGE_DST_WIDTH-1:0] dst;
        logic                       halt;
    } stage_entry_t;

    function automatic logic is_halt(input logic [TIA_OP_WIDTH-1:0] op);
        return op == TIA_OP_HALT;
    endfunction

endpackage

// File: rtl/fu_issue_skid_buffer.sv
// Two-entry {result, dst} FIFO between the FU stage and writeback.
// Only compiled when FU_ISSUE_OUTPUT_SKID_EN is defined.
`ifdef FU_ISSUE_OUTPUT_SKID_EN
module fu_issue_skid_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int DST_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_result,
    input  logic [DST_WIDTH-1:0]  push_dst,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [WORD_WIDTH-1:0] head_result,
    output logic [DST_WIDTH-1:0]  head_dst
);

    logic [WORD_WIDTH-1:0] result_q [2];
    logic [DST_WIDTH-1:0]  dst_q    [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  do_push;
    logic                  do_pop;

    assign full        = (count == 2'd2);
    assign empty       = (count == 2'd0);
    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;
    assign head_result = result_q[rd_ptr];
    assign head_dst    = dst_q[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q[0] <= '0;
            result_q[1] <= '0;
            dst_q[0]    <= '0;
            dst_q[1]    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (do_push) begin
                result_q[wr_ptr] <= push_result;
                dst_q[wr_ptr]    <= push_dst;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (!do_push && do_pop) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/fu_issue_controller.sv
// Issue side of the two-stage FU: handshakes instructions into the FU, tracks the
// in-flight stage, offers results on writeback, drains on HALT. Option: FU_ISSUE_OUTPUT_SKID_EN.
//
//   state  | meaning
//   RUN    | accepting instructions
//   DRAIN  | HALT accepted; waiting for the HALT entry (and any skid data) to leave
//   HALTED | idle until reset
module fu_issue_controller
    import fu_issue_controller_pkg::*;
#(
    parameter int DST_WIDTH     = 3,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TIA_OP_WIDTH-1:0]   in_op,
    input  logic [TIA_WORD_WIDTH-1:0] in_operand_0,
    input  logic [TIA_WORD_WIDTH-1:0] in_operand_1,
    input  logic [TIA_WORD_WIDTH-1:0] in_operand_2,
    input  logic [DST_WIDTH-1:0]      in_dst,
    output logic                      fu_enable,
    output logic [TIA_OP_WIDTH-1:0]   fu_op,
    output logic [TIA_WORD_WIDTH-1:0] fu_operand_0,
    output logic [TIA_WORD_WIDTH-1:0] fu_operand_1,
    output logic [TIA_WORD_WIDTH-1:0] fu_operand_2,
    input  logic [TIA_WORD_WIDTH-1:0] fu_result,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [TIA_WORD_WIDTH-1:0] wb_result,
    output logic [DST_WIDTH-1:0]      wb_dst,
    output logic                      halted,
    output logic [COUNTER_WIDTH-1:0]  issued_count,
    output logic [COUNTER_WIDTH-1:0]  retired_count
);

    if (DST_WIDTH != STAGE_DST_WIDTH) begin : g_dst_width_check
        $error("fu_issue_controller: DST_WIDTH must equal STAGE_DST_WIDTH");
    end

    issue_state_t state_q;
    issue_state_t state_d;
    stage_entry_t stage_q;
    logic         issue_fire;
    logic         retire;
    logic         stage_space;
    logic         drain_done;

    assign fu_op        = in_op;
    assign fu_operand_0 = in_operand_0;
    assign fu_operand_1 = in_operand_1;
    assign fu_operand_2 = in_operand_2;

    // reset gates in_ready so nothing is offered to the FU while reset is held
    assign in_ready   = reset & (state_q == RUN) & (~stage_q.valid | stage_space);
    assign issue_fire = in_valid & in_ready;
    assign fu_enable  = issue_fire;

`ifdef FU_ISSUE_OUTPUT_SKID_EN
    logic skid_full;
    logic skid_empty;
    logic skid_push;

    assign skid_push   = stage_q.valid & ~stage_q.halt & ~skid_full;
    assign retire      = stage_q.valid & (stage_q.halt | ~skid_full);
    assign stage_space = ~skid_full;
    assign drain_done  = skid_empty;
    assign wb_valid    = ~skid_empty;

    fu_issue_skid_buffer #(
        .WORD_WIDTH (TIA_WORD_WIDTH),
        .DST_WIDTH  (DST_WIDTH)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .push        (skid_push),
        .push_result (fu_result),
        .push_dst    (stage_q.dst),
        .pop         (wb_ready),
        .full        (skid_full),
        .empty       (skid_empty),
        .head_result (wb_result),
        .head_dst    (wb_dst)
    );
`else
    assign retire      = stage_q.valid & (stage_q.halt | wb_ready);
    assign stage_space = retire;
    assign drain_done  = 1'b1;
    assign wb_valid    = stage_q.valid & ~stage_q.halt;
    assign wb_result   = reset ? fu_result : '0;
    assign wb_dst      = stage_q.dst;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halted  = 1'b0;
        case (state_q)
            RUN:     if (issue_fire && is_halt(in_op)) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = HALTED;
            HALTED:  halted = 1'b1;
            default: state_d = RUN;
        endcase
    end

    // an issue in the same cycle as a retire simply overwrites the entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else if (issue_fire) begin
            stage_q.valid <= 1'b1;
            stage_q.dst   <= in_dst;
            stage_q.halt  <= is_halt(in_op);
        end else if (retire) begin
            stage_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issued_count  <= '0;
            retired_count <= '0;
        end else begin
            if (issue_fire) issued_count <= issued_count + COUNTER_WIDTH'(1);
            if (retire) retired_count <= retired_count + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fu_issue_controller.sv
// Self-checking bench for fu_issue_controller: vector table, HALT/reset sequences,
// and randomized traffic checked against an in-order writeback queue model.
`timescale 1ns/1ps
module tb_fu_issue_controller;
    import fu_issue_controller_pkg::*;

    localparam int DST_W = 3;
    localparam int CNT_W = 32;
    typedef logic [TIA_WORD_WIDTH-1:0] word_t;
    typedef logic [TIA_OP_WIDTH-1:0]   op_t;
    typedef logic [DST_W-1:0]          dst_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid;
    logic              in_ready;
    op_t               in_op;
    word_t             in_operand_0;
    word_t             in_operand_1;
    word_t             in_operand_2;
    dst_t              in_dst;
    logic              fu_enable;
    op_t               fu_op;
    word_t             fu_operand_0;
    word_t             fu_operand_1;
    word_t             fu_operand_2;
    word_t             fu_result = '0;
    logic              wb_valid;
    logic              wb_ready;
    word_t             wb_result;
    dst_t              wb_dst;
    logic              halted;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  retired_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fu_issue_controller #(.DST_WIDTH(DST_W), .COUNTER_WIDTH(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_operand_0(in_operand_0), .in_operand_1(in_operand_1), .in_operand_2(in_operand_2),
        .in_dst(in_dst), .fu_enable(fu_enable), .fu_op(fu_op),
        .fu_operand_0(fu_operand_0), .fu_operand_1(fu_operand_1), .fu_operand_2(fu_operand_2),
        .fu_result(fu_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_result(wb_result), .wb_dst(wb_dst), .halted(halted),
        .issued_count(issued_count), .retired_count(retired_count)
    );

    function automatic word_t alu(input op_t op, input word_t a, input word_t b, input word_t c);
        case (op)
            TIA_OP_MOV:  return a;
            TIA_OP_ADD:  return a + b;
            TIA_OP_SUB:  return a - b;
            TIA_OP_LMUL: return a * b;
            TIA_OP_LMAC: return a * b + c;
            TIA_OP_AND:  return a & b;
            TIA_OP_OR:   return a | b;
            TIA_OP_XOR:  return a ^ b;
            default:     return '0;
        endcase
    endfunction

    // registered FU: captures only when the controller enables it
    always @(posedge clock) begin
        if (fu_enable) fu_result <= alu(fu_op, fu_operand_0, fu_operand_1, fu_operand_2);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input op_t op, input word_t a, input word_t b,
                         input word_t c, input dst_t d, input logic wr);
        in_valid     = v;
        in_op        = op;
        in_operand_0 = a;
        in_operand_1 = b;
        in_operand_2 = c;
        in_dst       = d;
        wb_ready     = wr;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, TIA_OP_NOP, '0, '0, '0, '0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        word_t r;
        dst_t  d;
    } wb_exp_t;

    wb_exp_t exp_q[$];

    task automatic model_step(input string tag);
        wb_exp_t e;
        if (wb_valid && exp_q.size() != 0) begin
            check({tag, " wb_result"}, 64'(wb_result), 64'(exp_q[0].r));
            check({tag, " wb_dst"}, 64'(wb_dst), 64'(exp_q[0].d));
        end
        if (wb_valid && wb_ready) begin
            check({tag, " wb_pending"}, 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            e.r = alu(in_op, in_operand_0, in_operand_1, in_operand_2);
            e.d = in_dst;
            exp_q.push_back(e);
        end
    endtask

`ifndef FU_ISSUE_OUTPUT_SKID_EN
    typedef struct {
        logic v; op_t op; word_t a; word_t b; dst_t d; logic wr;
        logic e_ready; logic e_fen; logic e_wbv; word_t e_res; dst_t e_dst;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic v, input op_t op, input word_t a, input word_t b,
                                input dst_t d, input logic wr, input logic er, input logic ef,
                                input logic ev, input word_t eres, input dst_t ed);
        vec_t t;
        t.v = v; t.op = op; t.a = a; t.b = b; t.d = d; t.wr = wr;
        t.e_ready = er; t.e_fen = ef; t.e_wbv = ev; t.e_res = eres; t.e_dst = ed;
        return t;
    endfunction
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        op_t rand_ops [8];
        int  n_issued;
        int  n_wb;
        rand_ops[0] = TIA_OP_NOP;  rand_ops[1] = TIA_OP_MOV;  rand_ops[2] = TIA_OP_ADD;
        rand_ops[3] = TIA_OP_SUB;  rand_ops[4] = TIA_OP_LMUL; rand_ops[5] = TIA_OP_LMAC;
        rand_ops[6] = TIA_OP_AND;  rand_ops[7] = TIA_OP_XOR;

        // ---- reset state, with an instruction offered during reset
        drive(1'b1, TIA_OP_ADD, 32'd3, 32'd4, 32'd0, 3'd5, 1'b1);
        #12;
        check("rst in_ready", 64'(in_ready), 64'(0));
        check("rst fu_enable", 64'(fu_enable), 64'(0));
        check("rst wb_valid", 64'(wb_valid), 64'(0));
        check("rst halted", 64'(halted), 64'(0));
        check("rst issued", 64'(issued_count), 64'(0));
        check("rst retired", 64'(retired_count), 64'(0));
        check("rst wb_dst", 64'(wb_dst), 64'(0));
        check("rst fu_op passthru", 64'(fu_op), 64'(TIA_OP_ADD));
        check("rst fu_operand_1 passthru", 64'(fu_operand_1), 64'(4));
        do_reset();

`ifndef FU_ISSUE_OUTPUT_SKID_EN
        // ---- cycle-by-cycle vectors: single ADD, back-to-back, stall and release
        vecs[0] = mk(1, TIA_OP_ADD,  32'd3,  32'd4, 3'd5, 1, 1, 1, 0, 32'd0,  3'd0);
        vecs[1] = mk(1, TIA_OP_SUB,  32'd10, 32'd3, 3'd1, 1, 1, 1, 1, 32'd7,  3'd5);
        vecs[2] = mk(1, TIA_OP_LMUL, 32'd6,  32'd7, 3'd2, 1, 1, 1, 1, 32'd7,  3'd1);
        vecs[3] = mk(1, TIA_OP_ADD,  32'd1,  32'd1, 3'd3, 1, 1, 1, 1, 32'd42, 3'd2);
        vecs[4] = mk(1, TIA_OP_XOR,  32'd5,  32'd3, 3'd4, 0, 0, 0, 1, 32'd2,  3'd3);
        vecs[5] = mk(1, TIA_OP_XOR,  32'd5,  32'd3, 3'd4, 0, 0, 0, 1, 32'd2,  3'd3);
        vecs[6] = mk(1, TIA_OP_XOR,  32'd5,  32'd3, 3'd4, 0, 0, 0, 1, 32'd2,  3'd3);
        vecs[7] = mk(1, TIA_OP_XOR,  32'd5,  32'd3, 3'd4, 1, 1, 1, 1, 32'd2,  3'd3);
        vecs[8] = mk(0, TIA_OP_NOP,  32'd0,  32'd0, 3'd0, 1, 1, 0, 1, 32'd6,  3'd4);
        vecs[9] = mk(0, TIA_OP_NOP,  32'd0,  32'd0, 3'd0, 1, 1, 0, 0, 32'd0,  3'd0);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, 32'd0, vecs[i].d, vecs[i].wr);
            @(negedge clock);
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d fu_enable", i), 64'(fu_enable), 64'(vecs[i].e_fen));
            check($sformatf("vec%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].e_wbv));
            if (vecs[i].e_wbv) begin
                check($sformatf("vec%0d wb_result", i), 64'(wb_result), 64'(vecs[i].e_res));
                check($sformatf("vec%0d wb_dst", i), 64'(wb_dst), 64'(vecs[i].e_dst));
            end
        end
        check("vec issued", 64'(issued_count), 64'(5));
        check("vec retired", 64'(retired_count), 64'(5));

        // ---- MOV then HALT: silent HALT retire, halted two cycles after HALT issue
        do_reset();
        next_cycle();
        drive(1, TIA_OP_MOV, 32'd9, 32'd0, 32'd0, 3'd2, 1);
        @(negedge clock);
        check("halt mov in_ready", 64'(in_ready), 64'(1));
        next_cycle();
        drive(1, TIA_OP_HALT, 32'd0, 32'd0, 32'd0, 3'd0, 1);
        @(negedge clock);
        check("halt issue in_ready", 64'(in_ready), 64'(1));
        check("halt mov wb_valid", 64'(wb_valid), 64'(1));
        check("halt mov wb_result", 64'(wb_result), 64'(9));
        check("halt mov wb_dst", 64'(wb_dst), 64'(2));
        next_cycle();
        drive(1, TIA_OP_ADD, 32'd1, 32'd1, 32'd0, 3'd1, 1);
        @(negedge clock);
        check("drain in_ready", 64'(in_ready), 64'(0));
        check("drain fu_enable", 64'(fu_enable), 64'(0));
        check("drain wb_valid", 64'(wb_valid), 64'(0));
        check("drain halted", 64'(halted), 64'(0));
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clock);
            check($sformatf("halted%0d halted", k), 64'(halted), 64'(1));
            check($sformatf("halted%0d in_ready", k), 64'(in_ready), 64'(0));
            check($sformatf("halted%0d fu_enable", k), 64'(fu_enable), 64'(0));
            check($sformatf("halted%0d wb_valid", k), 64'(wb_valid), 64'(0));
        end
        check("halt issued", 64'(issued_count), 64'(2));
        check("halt retired", 64'(retired_count), 64'(2));
        #2 reset = 1'b0;
        #1;
        check("halt async rst halted", 64'(halted), 64'(0));
        check("halt async rst issued", 64'(issued_count), 64'(0));
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
`else
        // ---- skid: three accepts with writeback blocked, then in-order drain
        begin
            int accepted;
            int drained;
            accepted = 0;
            drained  = 0;
            exp_q.delete();
            do_reset();
            for (int i = 0; i < 6; i++) begin
                next_cycle();
                drive(1, TIA_OP_ADD, word_t'(i + 1), word_t'(10 * i), 32'd0, dst_t'(i), 0);
                @(negedge clock);
                if (in_valid && in_ready) accepted++;
                model_step("skid fill");
            end
            check("skid accepted", 64'(accepted), 64'(3));
            check("skid full in_ready", 64'(in_ready), 64'(0));
            for (int i = 0; i < 10; i++) begin
                next_cycle();
                drive(0, TIA_OP_NOP, '0, '0, '0, '0, 1);
                @(negedge clock);
                if (wb_valid && wb_ready) drained++;
                model_step("skid drain");
            end
            check("skid drained", 64'(drained), 64'(3));
            check("skid queue empty", 64'(exp_q.size()), 64'(0));
        end
`endif

        // ---- async reset mid-stall drops the in-flight entry
        do_reset();
        next_cycle();
        drive(1, TIA_OP_ADD, 32'd2, 32'd5, 32'd0, 3'd6, 0);
        @(negedge clock);
        check("stall accept", 64'(in_ready), 64'(1));
        next_cycle();
        drive(1, TIA_OP_SUB, 32'd8, 32'd1, 32'd0, 3'd1, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                @(negedge clock);
                if (wb_valid) seen = 1'b1;
            end
            check("stall wb_valid seen", 64'(seen), 64'(1));
        end
        check("stall wb_result", 64'(wb_result), 64'(7));
        check("stall wb_dst", 64'(wb_dst), 64'(6));
        #2 reset = 1'b0;
        #1;
        check("async rst wb_valid", 64'(wb_valid), 64'(0));
        check("async rst issued", 64'(issued_count), 64'(0));
        check("async rst retired", 64'(retired_count), 64'(0));
        check("async rst halted", 64'(halted), 64'(0));
        check("async rst in_ready", 64'(in_ready), 64'(0));
        check("async rst fu_enable", 64'(fu_enable), 64'(0));
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // ---- randomized traffic against the in-order writeback model
        do_reset();
        exp_q.delete();
        n_issued = 0;
        n_wb     = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            next_cycle();
            drive($urandom_range(0, 9) < 6, rand_ops[$urandom_range(0, 7)],
                  word_t'($urandom()), word_t'($urandom()), word_t'($urandom()),
                  dst_t'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            @(negedge clock);
`ifndef FU_ISSUE_OUTPUT_SKID_EN
            check("rand in_ready", 64'(in_ready), 64'((exp_q.size() == 0) || wb_ready));
            check("rand wb_valid", 64'(wb_valid), 64'(exp_q.size() != 0));
`endif
            if (in_valid && in_ready) n_issued++;
            if (wb_valid && wb_ready) n_wb++;
            model_step("rand");
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            next_cycle();
            drive(0, TIA_OP_NOP, '0, '0, '0, '0, 1);
            @(negedge clock);
            if (wb_valid && wb_ready) n_wb++;
            model_step("rand drain");
        end
        check("rand queue empty", 64'(exp_q.size()), 64'(0));
        check("rand wb count", 64'(n_wb), 64'(n_issued));
        check("rand issued", 64'(issued_count), 64'(n_issued));
        check("rand retired", 64'(retired_count), 64'(n_issued));
        check("rand halted", 64'(halted), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
